// File: rtl/edge_pkg.sv
// rtl/edge_pkg.sv - shared state type and default frame geometry for window_ctrl
package edge_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      FLUSH  = 2'd2
   } win_state_t;

   localparam int DEF_IMG_WIDTH  = 720;
   localparam int DEF_IMG_HEIGHT = 540;

endpackage

// File: rtl/pixel_pos_counter.sv
// rtl/pixel_pos_counter.sv - raster row/col counter advanced once per accepted pixel
module pixel_pos_counter
   import edge_pkg::*;
#(
   parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
   parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
   parameter int COL_W      = $clog2(IMG_WIDTH),
   parameter int ROW_W      = $clog2(IMG_HEIGHT)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear,
   input  logic             en,
   output logic [ROW_W-1:0] row,
   output logic [COL_W-1:0] col,
   output logic             last_col,
   output logic             last_pix
);

   // Exact equality against the last index keeps all arithmetic inside COL_W/ROW_W.
   assign last_col = (col == COL_W'(IMG_WIDTH - 1));
   assign last_pix = last_col & (row == ROW_W'(IMG_HEIGHT - 1));

   // Advance in raster order; the final pixel wraps both counters back to the origin.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         row <= '0;
         col <= '0;
      end else if (clear) begin
         row <= '0;
         col <= '0;
      end else if (en) begin
         if (last_col) begin
            col <= '0;
            row <= last_pix ? '0 : row + 1'b1;
         end else begin
            col <= col + 1'b1;
         end
      end
   end

endmodule

// File: rtl/window_ctrl.sv
// rtl/window_ctrl.sv - 3x3 line-buffer sequencer; optional stall counter under WINDOW_CTRL_STALL_CNT_EN
module window_ctrl
   import edge_pkg::*;
#(
   parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
   parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
   parameter int COL_W      = $clog2(IMG_WIDTH),
   parameter int ROW_W      = $clog2(IMG_HEIGHT)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             shift_en,
   input  logic             out_ready,
   output logic             win_valid,
   output logic [ROW_W-1:0] win_row,
   output logic [COL_W-1:0] win_col,
   output logic             busy,
   output logic             frame_done
`ifdef WINDOW_CTRL_STALL_CNT_EN
   ,
   output logic [31:0]      stall_cycles
`endif
);

   win_state_t       state;
   win_state_t       state_nxt;
   logic [ROW_W-1:0] row;
   logic [COL_W-1:0] col;
   logic             last_col;
   logic             last_pix;
   logic             start_acc;
   logic             win_free;
   logic             win_hit;

   assign start_acc = (state == IDLE) & start;
   // The held window may be replaced only when it is absent or being consumed now.
   assign win_free  = ~win_valid | out_ready;
   assign in_ready  = (state == STREAM) & win_free;
   assign shift_en  = in_valid & in_ready;
   assign busy      = (state != IDLE);
   // Taps hold a full 3x3 neighbourhood only once two rows and two columns are behind.
   assign win_hit   = (row >= ROW_W'(2)) & (col >= COL_W'(2));

   pixel_pos_counter #(
      .IMG_WIDTH (IMG_WIDTH),
      .IMG_HEIGHT(IMG_HEIGHT),
      .COL_W     (COL_W),
      .ROW_W     (ROW_W)
   ) u_pos (
      .clock   (clock),
      .reset   (reset),
      .clear   (start_acc),
      .en      (shift_en),
      .row     (row),
      .col     (col),
      .last_col(last_col),
      .last_pix(last_pix)
   );

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and end-of-frame pulse; FLUSH waits for the final window to drain.
   always_comb begin
      state_nxt  = state;
      frame_done = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = STREAM;
            end
         end
         STREAM: begin
            if (shift_en & last_pix) begin
               state_nxt = FLUSH;
            end
         end
         FLUSH: begin
            if (win_free) begin
               state_nxt  = IDLE;
               frame_done = 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Window register: a shift loads the new window (or clears it), otherwise hold until consumed.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         win_valid <= 1'b0;
         win_row   <= '0;
         win_col   <= '0;
      end else if (shift_en) begin
         win_valid <= win_hit;
         if (win_hit) begin
            win_row <= row - ROW_W'(1);
            win_col <= col - COL_W'(1);
         end
      end else if (win_valid & out_ready) begin
         win_valid <= 1'b0;
      end
   end

`ifdef WINDOW_CTRL_STALL_CNT_EN
   // Count cycles where upstream offers a pixel but a held window blocks it; saturating.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         stall_cycles <= '0;
      end else if (start_acc) begin
         stall_cycles <= '0;
      end else if ((state == STREAM) & in_valid & ~in_ready & (stall_cycles != 32'hFFFF_FFFF)) begin
         stall_cycles <= stall_cycles + 32'd1;
      end
   end
`endif

endmodule
